sap_mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 16x8 synchronous SAP memory.
- Requester A is the CPU controller (fetch/LDA/STA); requester B is the program loader or a debug port.
- Serialises both requesters onto the memory's enable/we/address/bidirectional-data interface, using round-robin fairness and a req/ack handshake.
- Owns the memory data bus direction: it drives the bus only during write accesses.

---
 rtl/sap_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_sap_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_mem_arbiter.sv
// sap_mem_arbiter: round-robin arbiter/sequencer for the shared 16x8 SAP memory.
// Requester A (CPU controller) and requester B (loader/debug) are serialised
// onto a single memory port with a req/ack handshake. Each access runs
// IDLE -> ACCESS -> DONE, and the ack pulse is high during DONE.
// Optional feature macro: SAP_ARB_LOCK_EN. When it is defined, a b_lock held
// on a contested IDLE sample gives B the grant without moving the
// round-robin pointer, which lets the loader do burst fills.
module sap_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nx;
  logic              last_b, last_b_nx;
  logic              sel_b, sel_b_nx;
  logic              lat_we, lat_we_nx;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nx;
  logic              en_nx, we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              a_ack_nx, b_ack_nx;
  logic [DATA_W-1:0] a_rdata_nx, b_rdata_nx;
  logic              take_a, take_b;

`ifndef SAP_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = b_lock;
`endif

  // The arbiter drives the bus only for a write, and only while mem_we is high.
  assign mem_data = (mem_enable && mem_we) ? lat_wdata : {DATA_W{1'bz}};

  // Arbitration, grant latching, read capture and ack generation.
  always_comb begin
    state_nx     = state;
    last_b_nx    = last_b;
    sel_b_nx     = sel_b;
    lat_we_nx    = lat_we;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    en_nx        = 1'b0;
    we_nx        = 1'b0;
    addr_nx      = mem_address;
    a_ack_nx     = 1'b0;
    b_ack_nx     = 1'b0;
    a_rdata_nx   = a_rdata;
    b_rdata_nx   = b_rdata;
    take_a       = 1'b0;
    take_b       = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req && b_req) begin
`ifdef SAP_ARB_LOCK_EN
          if (b_lock) begin
            take_b = 1'b1;
          end else begin
            take_a    = last_b;
            take_b    = !last_b;
            last_b_nx = !last_b;
          end
`else
          take_a    = last_b;
          take_b    = !last_b;
          last_b_nx = !last_b;
`endif
        end else begin
          take_a = a_req;
          take_b = b_req;
        end
        if (take_a || take_b) begin
          sel_b_nx     = take_b;
          lat_we_nx    = take_b ? b_we    : a_we;
          lat_addr_nx  = take_b ? b_addr  : a_addr;
          lat_wdata_nx = take_b ? b_wdata : a_wdata;
          en_nx        = 1'b1;
          we_nx        = lat_we_nx;
          addr_nx      = lat_addr_nx;
          state_nx     = ACCESS;
        end
      end
      ACCESS: begin
        if (!lat_we) begin
          if (sel_b) b_rdata_nx = mem_data;
          else       a_rdata_nx = mem_data;
        end
        a_ack_nx = !sel_b;
        b_ack_nx = sel_b;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset drops mem_enable at once, so an interrupted write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      sel_b       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      mem_enable  <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      last_b      <= last_b_nx;
      sel_b       <= sel_b_nx;
      lat_we      <= lat_we_nx;
      lat_addr    <= lat_addr_nx;
      lat_wdata   <= lat_wdata_nx;
      mem_enable  <= en_nx;
      mem_we      <= we_nx;
      mem_address <= addr_nx;
      a_ack       <= a_ack_nx;
      b_ack       <= b_ack_nx;
      a_rdata     <= a_rdata_nx;
      b_rdata     <= b_rdata_nx;
      busy        <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// tb_sap_mem_arbiter: scoreboard bench for sap_mem_arbiter with a 16x8 memory model.
// The expected memory accesses and per-port acks are queued when stimulus is
// issued. A negedge monitor pops those queues and compares them against
// what the DUT does. The lock-order vectors follow SAP_ARB_LOCK_EN.
module tb_sap_mem_arbiter;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] data;
  } ack_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       a_ack;
  logic [7:0] a_rdata;
  logic       b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       b_ack;
  logic [7:0] b_rdata;
  logic       mem_enable, mem_we, busy;
  logic [3:0] mem_address;
  wire  [7:0] mem_data;

  logic [7:0] mem_arr [16];
  acc_t       acc_q[$];
  ack_t       a_q[$];
  ack_t       b_q[$];
  int         total = 0;
  int         passed = 0;
  logic [7:0] a_model = '0, b_model = '0;
  logic       prev_en = 1'b0;

  sap_mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_enable(mem_enable), .mem_we(mem_we), .mem_address(mem_address),
    .mem_data(mem_data), .busy(busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Memory model: combinational read onto the bus, write committed on posedge.
  assign mem_data = (mem_enable && !mem_we) ? mem_arr[mem_address] : 8'hzz;

  // Memory write port.
  always @(posedge clk) begin
    if (mem_enable && mem_we) mem_arr[mem_address] <= mem_data;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_arr[i] = 8'h10 + 8'(i);
    mem_arr[15] = 8'hA7;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_acc(input logic we, input logic [3:0] addr, input logic [7:0] data);
    acc_t e;
    e.we = we; e.addr = addr; e.data = data;
    acc_q.push_back(e);
  endtask

  task automatic apply_a(input logic we, input logic [3:0] addr, input logic [7:0] val);
    ack_t e;
    int n;
    e.rd = !we; e.data = val;
    a_q.push_back(e);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = val;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!a_ack && n < 60);
    if (!a_ack) check_output("a_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic apply_b(input logic we, input logic [3:0] addr, input logic [7:0] val);
    ack_t e;
    int n;
    e.rd = !we; e.data = val;
    b_q.push_back(e);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = val;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b_ack && n < 60);
    if (!b_ack) check_output("b_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every memory access and ack against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_model = '0;
      b_model = '0;
      prev_en = 1'b0;
    end else begin
      check_output("busy", busy, mem_enable || a_ack || b_ack);
      if (!mem_enable) check_output("bus_released", mem_data === 8'hzz, 1'b1);
      if (mem_enable) begin
        if (acc_q.size() == 0) begin
          check_output("unexpected_access", 32'd1, 32'd0);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          check_output("mem_we", mem_we, e.we);
          check_output("mem_address", mem_address, e.addr);
          if (e.we) check_output("mem_wdata", mem_data, e.data);
          else      check_output("bus_no_x", $isunknown(mem_data), 1'b0);
        end
      end
      if (a_ack) begin
        check_output("a_ack_after_access", prev_en, 1'b1);
        check_output("b_rdata_held", b_rdata, b_model);
        if (a_q.size() == 0) begin
          check_output("unexpected_a_ack", 32'd1, 32'd0);
        end else begin
          ack_t e;
          e = a_q.pop_front();
          if (e.rd) a_model = e.data;
          check_output("a_rdata", a_rdata, a_model);
        end
      end
      if (b_ack) begin
        check_output("b_ack_after_access", prev_en, 1'b1);
        check_output("a_rdata_held", a_rdata, a_model);
        if (b_q.size() == 0) begin
          check_output("unexpected_b_ack", 32'd1, 32'd0);
        end else begin
          ack_t e;
          e = b_q.pop_front();
          if (e.rd) b_model = e.data;
          check_output("b_rdata", b_rdata, b_model);
        end
      end
      prev_en = mem_enable;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_mem_enable", mem_enable, 1'b0);
    check_output("rst_mem_we", mem_we, 1'b0);
    check_output("rst_mem_address", mem_address, 4'h0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_acks", {a_ack, b_ack}, 2'b00);
    check_output("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
    check_output("rst_bus", mem_data === 8'hzz, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(2);

    // A write then read back.
    push_acc(1'b1, 4'h5, 8'h3C);
    apply_a(1'b1, 4'h5, 8'h3C);
    push_acc(1'b0, 4'h5, 8'h00);
    apply_a(1'b0, 4'h5, 8'h3C);
    a_req = 1'b0;
    idle_cycles(3);

    // Both requesting: strict alternation starting with A.
    for (int i = 0; i < 4; i++) begin
      push_acc(1'b1, 4'h1, 8'h40 + 8'(i));
      push_acc(1'b0, 4'h2, 8'h00);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) apply_a(1'b1, 4'h1, 8'h40 + 8'(i));
        a_req = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) apply_b(1'b0, 4'h2, 8'h12);
        b_req = 1'b0;
      end
    join
    idle_cycles(3);

    // B read of the preloaded top address.
    push_acc(1'b0, 4'hF, 8'h00);
    apply_b(1'b0, 4'hF, 8'hA7);
    b_req = 1'b0;
    idle_cycles(3);

    // Reset in the middle of an A write must abort it.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h3; a_wdata = 8'h99;
    @(posedge clk); #1;
    check_output("abort_in_access", mem_enable, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_output("abort_mem_enable", mem_enable, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_a_ack", a_ack, 1'b0);
    check_output("abort_bus", mem_data === 8'hzz, 1'b1);
    a_req = 1'b0;
    @(posedge clk); #1;
    check_output("abort_no_ack", {a_ack, b_ack}, 2'b00);
    check_output("abort_rdata", {a_rdata, b_rdata}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(2);
    push_acc(1'b0, 4'h3, 8'h00);
    apply_a(1'b0, 4'h3, 8'h13);
    a_req = 1'b0;
    idle_cycles(3);

    // req held across ack with a new address: one access each, no duplicate.
    push_acc(1'b0, 4'h5, 8'h00);
    push_acc(1'b0, 4'h7, 8'h00);
    apply_a(1'b0, 4'h5, 8'h3C);
    apply_a(1'b0, 4'h7, 8'h17);
    a_req = 1'b0;
    idle_cycles(6);

    // Contention with B holding b_lock during a burst fill.
`ifdef SAP_ARB_LOCK_EN
    push_acc(1'b1, 4'h8, 8'h80);
    push_acc(1'b1, 4'h9, 8'h81);
    push_acc(1'b1, 4'hA, 8'h82);
    push_acc(1'b0, 4'hF, 8'h00);
    push_acc(1'b0, 4'h1, 8'h00);
`else
    push_acc(1'b0, 4'hF, 8'h00);
    push_acc(1'b1, 4'h8, 8'h80);
    push_acc(1'b0, 4'h1, 8'h00);
    push_acc(1'b1, 4'h9, 8'h81);
    push_acc(1'b1, 4'hA, 8'h82);
`endif
    fork
      begin
        apply_a(1'b0, 4'hF, 8'hA7);
        apply_a(1'b0, 4'h1, 8'h43);
        a_req = 1'b0;
      end
      begin
        b_lock = 1'b1;
        apply_b(1'b1, 4'h8, 8'h80);
        apply_b(1'b1, 4'h9, 8'h81);
        apply_b(1'b1, 4'hA, 8'h82);
        b_req = 1'b0;
        b_lock = 1'b0;
      end
    join
    idle_cycles(6);

    check_output("acc_q_drained", acc_q.size(), 32'd0);
    check_output("a_q_drained", a_q.size(), 32'd0);
    check_output("b_q_drained", b_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
